rep_umul_sched: RTL and testbench

- Round-robin scheduler that shares one rep_uMUL unary multiplier between NREQ requesters.
- Accepts one (A, B) job per grant and sequences the multiplier: loadB, a full 2^BITWIDTH-cycle enable window, result capture, then clear.
- Returns the product with the requester ID over a valid/ready result port.
- Sits between the requester fabric and the rep_uMUL instance; drives all multiplier control pins.

---
 rtl/rep_umul_sched_if.sv | 42 ++++
 rtl/rep_umul_sched.sv | 156 +++++++++++++++
 tb/tb_rep_umul_sched.sv | 252 +++++++++++++++++++++++++
 3 files changed

// File: rtl/rep_umul_sched_if.sv
// Job, multiplier-control and result signals between rep_umul_sched and its environment.
// The iAbort signal exists only when REP_UMUL_SCHED_ABORT_EN is defined.
interface rep_umul_sched_if #(
   parameter int BITWIDTH = 8,
   parameter int NREQ     = 2,
   parameter int IDW      = 3
);
   logic [NREQ-1:0]          iReqVld;
   logic [NREQ*BITWIDTH-1:0] iReqA;
   logic [NREQ*BITWIDTH-1:0] iReqB;
   logic [NREQ-1:0]          oReqRdy;
   logic [BITWIDTH-1:0]      oA;
   logic [BITWIDTH-1:0]      oB;
   logic                     oLoadB;
   logic                     oEn;
   logic                     oClr;
   logic [BITWIDTH-1:0]      iMult;
   logic                     oRsltVld;
   logic [BITWIDTH-1:0]      oRslt;
   logic [IDW-1:0]           oRsltId;
   logic                     iRsltRdy;
   logic                     oBusy;
`ifdef REP_UMUL_SCHED_ABORT_EN
   logic                     iAbort;
`endif

   modport slave (
`ifdef REP_UMUL_SCHED_ABORT_EN
      input  iAbort,
`endif
      input  iReqVld, iReqA, iReqB, iMult, iRsltRdy,
      output oReqRdy, oA, oB, oLoadB, oEn, oClr, oRsltVld, oRslt, oRsltId, oBusy
   );

   modport master (
`ifdef REP_UMUL_SCHED_ABORT_EN
      output iAbort,
`endif
      output iReqVld, iReqA, iReqB, iMult, iRsltRdy,
      input  oReqRdy, oA, oB, oLoadB, oEn, oClr, oRsltVld, oRslt, oRsltId, oBusy
   );
endinterface

// File: rtl/rep_umul_sched.sv
// Round-robin sharing of one rep_uMUL: grant, loadB, 2^BITWIDTH enable cycles, capture, clear (2^BITWIDTH+4 cycles/job).
// An unconsumed result blocks new grants only; REP_UMUL_SCHED_ABORT_EN adds iAbort to cut a job short in LOAD/RUN.
module rep_umul_sched #(
   parameter int BITWIDTH = 8,
   parameter int NREQ     = 2,
   parameter int IDW      = 3
) (
   input  logic            iClk,
   input  logic            iRstN,
   rep_umul_sched_if.slave sif
);
   typedef enum logic [2:0] {IDLE, LOAD, RUN, CAPT, CLEAR} state_e;

   state_e              state_q, state_d;
   logic [BITWIDTH-1:0] cnt_q, cnt_d;
   logic [IDW-1:0]      ptr_q, ptr_d;
   logic [IDW-1:0]      id_q, id_d;
   logic [BITWIDTH-1:0] a_q, a_d;
   logic [BITWIDTH-1:0] b_q, b_d;
   logic [BITWIDTH-1:0] rslt_q, rslt_d;
   logic [IDW-1:0]      rslt_id_q, rslt_id_d;
   logic                rslt_vld_q, rslt_vld_d;
   logic                load_b_q, load_b_d;
   logic                en_q, en_d;
   logic                clr_q, clr_d;

   logic                gnt_found;
   logic                grant;
   logic                abort;
   logic [IDW-1:0]      gnt_off;
   logic [IDW:0]        gnt_sum;
   logic [IDW-1:0]      gnt_idx;
   logic [2*NREQ-1:0]   rot;

`ifdef REP_UMUL_SCHED_ABORT_EN
   assign abort = sif.iAbort;
`else
   assign abort = 1'b0;
`endif

   // Rotate the doubled request vector so bit 0 is the pointer position, then pick the lowest set bit.
   always_comb begin
      gnt_found = 1'b0;
      gnt_off   = '0;
      rot       = {sif.iReqVld, sif.iReqVld} >> ptr_q;
      for (int k = 0; k < NREQ; k++) begin
         if (!gnt_found && rot[0]) begin
            gnt_found = 1'b1;
            gnt_off   = IDW'(k);
         end
         rot = rot >> 1;
      end
      gnt_sum = {1'b0, ptr_q} + {1'b0, gnt_off};
      if (gnt_sum >= (IDW+1)'(NREQ)) begin
         gnt_sum = gnt_sum - (IDW+1)'(NREQ);
      end
      gnt_idx = gnt_sum[IDW-1:0];
   end

   assign grant = (state_q == IDLE) && gnt_found && (!rslt_vld_q || sif.iRsltRdy);

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      unique case (state_q)
         IDLE:    if (grant) state_d = LOAD;
         LOAD: begin
            cnt_d   = '0;
            state_d = abort ? CLEAR : RUN;
         end
         RUN: begin
            cnt_d = cnt_q + 1'b1;
            if (abort)       state_d = CLEAR;
            else if (&cnt_q) state_d = CAPT;
         end
         CAPT:    state_d = CLEAR;
         CLEAR:   state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // Control pins decode the next state so they are registered and aligned with the state they belong to.
   always_comb begin
      a_d        = a_q;
      b_d        = b_q;
      id_d       = id_q;
      ptr_d      = ptr_q;
      rslt_d     = rslt_q;
      rslt_id_d  = rslt_id_q;
      rslt_vld_d = rslt_vld_q;
      if (grant) begin
         a_d   = BITWIDTH'(sif.iReqA >> (gnt_idx * BITWIDTH));
         b_d   = BITWIDTH'(sif.iReqB >> (gnt_idx * BITWIDTH));
         id_d  = gnt_idx;
         ptr_d = (gnt_idx == IDW'(NREQ - 1)) ? '0 : gnt_idx + 1'b1;
      end
      if (rslt_vld_q && sif.iRsltRdy) begin
         rslt_vld_d = 1'b0;
      end
      if (state_q == CAPT) begin
         rslt_d     = sif.iMult;
         rslt_id_d  = id_q;
         rslt_vld_d = 1'b1;
      end
      load_b_d = (state_d == LOAD);
      en_d     = (state_d == RUN);
      clr_d    = (state_d == CLEAR);
   end

   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         cnt_q      <= '0;
         ptr_q      <= '0;
         id_q       <= '0;
         a_q        <= '0;
         b_q        <= '0;
         rslt_q     <= '0;
         rslt_id_q  <= '0;
         rslt_vld_q <= 1'b0;
         load_b_q   <= 1'b0;
         en_q       <= 1'b0;
         clr_q      <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         ptr_q      <= ptr_d;
         id_q       <= id_d;
         a_q        <= a_d;
         b_q        <= b_d;
         rslt_q     <= rslt_d;
         rslt_id_q  <= rslt_id_d;
         rslt_vld_q <= rslt_vld_d;
         load_b_q   <= load_b_d;
         en_q       <= en_d;
         clr_q      <= clr_d;
      end
   end

   assign sif.oReqRdy  = (grant && iRstN) ? (NREQ'(1) << gnt_idx) : '0;
   assign sif.oA       = a_q;
   assign sif.oB       = b_q;
   assign sif.oLoadB   = load_b_q;
   assign sif.oEn      = en_q;
   assign sif.oClr     = clr_q;
   assign sif.oRsltVld = rslt_vld_q;
   assign sif.oRslt    = rslt_q;
   assign sif.oRsltId  = rslt_id_q;
   assign sif.oBusy    = (state_q != IDLE);
endmodule

// File: tb/tb_rep_umul_sched.sv
// Directed bench for rep_umul_sched with a behavioural unary multiplier (A as thermometer run, B accumulated per enable).
// Abort sequence is compiled in only with REP_UMUL_SCHED_ABORT_EN.
module tb_rep_umul_sched;
   localparam int BW   = 8;
   localparam int NR   = 2;
   localparam int IW   = 3;
   localparam int RUNL = 1 << BW;
   localparam int SPAC = RUNL + 4;

   logic iClk  = 1'b0;
   logic iRstN = 1'b0;
   int   cyc   = 0;
   int   total = 0;
   int   bad   = 0;

   rep_umul_sched_if #(.BITWIDTH(BW), .NREQ(NR), .IDW(IW)) sif ();
   rep_umul_sched #(.BITWIDTH(BW), .NREQ(NR), .IDW(IW)) dut (
      .iClk (iClk),
      .iRstN(iRstN),
      .sif  (sif)
   );

   always #5 iClk = ~iClk;
   always @(posedge iClk) cyc <= cyc + 1;

   logic [15:0]   acc;
   logic [8:0]    mcnt;
   logic [BW-1:0] mb;
   always_ff @(posedge iClk or negedge iRstN) begin
      if (!iRstN) begin
         acc <= '0; mcnt <= '0; mb <= '0;
      end else if (sif.oClr) begin
         acc <= '0; mcnt <= '0;
      end else if (sif.oLoadB) begin
         mb <= sif.oB; mcnt <= '0;
      end else if (sif.oEn) begin
         if (mcnt < {1'b0, sif.oA}) acc <= acc + 16'(mb);
         mcnt <= mcnt + 9'd1;
      end
   end
   assign sif.iMult = acc[15:8];

   int gq_idx[$];
   int gq_cyc[$];
   always begin
      @(negedge iClk);
      #2;
      if (sif.oReqRdy != '0) begin
         gq_idx.push_back(sif.oReqRdy[1] ? 1 : 0);
         gq_cyc.push_back(cyc);
      end
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation still running, required finish");
      $fatal(1, "timeout");
   end

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic set_req(input int req, input int a, input int b);
      sif.iReqA[req*BW +: BW] = BW'(a);
      sif.iReqB[req*BW +: BW] = BW'(b);
      sif.iReqVld[req] = 1'b1;
   endtask

   // Called just after a negedge; returns the grant cycle or -1 if none within the budget.
   task automatic wait_rdy(input int req, output int g);
      g = -1;
      for (int k = 0; k < 1000 && g < 0; k++) begin
         #1;
         if (sif.oReqRdy[req]) g = cyc;
         else @(negedge iClk);
      end
   endtask

   task automatic run_job(input string nm, input int req, input int a, input int b, input int exp_r);
      int g, ld, en_n, vo, co, rs, ri, ovl;
      set_req(req, a, b);
      wait_rdy(req, g);
      chk({nm, " granted"}, int'(g >= 0), 1);
      @(posedge iClk);
      #1;
      sif.iReqVld[req] = 1'b0;
      ld = -1; en_n = 0; vo = -1; co = -1; rs = -1; ri = -1; ovl = 0;
      for (int k = 1; k <= 400 && co < 0; k++) begin
         @(negedge iClk);
         if (sif.oLoadB && ld < 0) ld = k;
         if (sif.oEn) en_n++;
         if (sif.oRsltVld && vo < 0) begin
            vo = k; rs = int'(sif.oRslt); ri = int'(sif.oRsltId);
         end
         if (sif.oClr) co = k;
         if (int'(sif.oLoadB) + int'(sif.oEn) + int'(sif.oClr) > 1) ovl++;
      end
      chk({nm, " loadB cycle"}, ld, 1);
      chk({nm, " en cycles"}, en_n, RUNL);
      chk({nm, " rslt vld cycle"}, vo, RUNL + 3);
      chk({nm, " clr cycle"}, co, RUNL + 3);
      chk({nm, " rslt"}, rs, exp_r);
      chk({nm, " rslt id"}, ri, req);
      chk({nm, " ctrl overlap"}, ovl, 0);
   endtask

   typedef struct {
      string nm;
      int    req;
      int    a;
      int    b;
      int    exp_r;
   } vec_t;

   initial begin
      vec_t vt[6];
      int   g, base, en_n, cnt;
      vt[0] = '{"v134x128", 0, 134, 128, 67};
      vt[1] = '{"v255x255_wrap", 0, 255, 255, 254};
      vt[2] = '{"v0x200", 1, 0, 200, 0};
      vt[3] = '{"v200x0_wrap", 1, 200, 0, 0};
      vt[4] = '{"v16x16", 0, 16, 16, 1};
      vt[5] = '{"v100x50", 1, 100, 50, 19};

      sif.iReqVld = '0; sif.iReqA = '0; sif.iReqB = '0; sif.iRsltRdy = 1'b1;
`ifdef REP_UMUL_SCHED_ABORT_EN
      sif.iAbort = 1'b0;
`endif
      #1;
      chk("rst oReqRdy", int'(sif.oReqRdy), 0);
      chk("rst oLoadB", int'(sif.oLoadB), 0);
      chk("rst oEn", int'(sif.oEn), 0);
      chk("rst oClr", int'(sif.oClr), 0);
      chk("rst oRsltVld", int'(sif.oRsltVld), 0);
      chk("rst oRslt", int'(sif.oRslt), 0);
      chk("rst oBusy", int'(sif.oBusy), 0);
      chk("rst oA", int'(sif.oA), 0);
      repeat (3) @(negedge iClk);
      iRstN = 1'b1;
      @(negedge iClk);

      for (int i = 0; i < 6; i++) run_job(vt[i].nm, vt[i].req, vt[i].a, vt[i].b, vt[i].exp_r);

      // Round robin with both requesters held
      base = gq_idx.size();
      set_req(0, 3, 4);
      set_req(1, 5, 6);
      for (int k = 0; k < 1500 && gq_idx.size() < base + 4; k++) @(negedge iClk);
      sif.iReqVld = '0;
      for (int k = 0; k < 400 && sif.oBusy; k++) @(negedge iClk);
      chk("rr grant count", gq_idx.size() - base, 4);
      if (gq_idx.size() >= base + 4) begin
         for (int i = 0; i < 4; i++) chk("rr order", gq_idx[base+i], i % 2);
         for (int i = 1; i < 4; i++) chk("rr spacing", gq_cyc[base+i] - gq_cyc[base+i-1], SPAC);
      end

      // Backpressure: result held, pending requester 1 must wait
      sif.iRsltRdy = 1'b0;
      base = gq_idx.size();
      set_req(0, 200, 100);
      wait_rdy(0, g);
      chk("bp job0 granted", int'(g >= 0), 1);
      @(posedge iClk);
      #1;
      sif.iReqVld[0] = 1'b0;
      set_req(1, 50, 60);
      repeat (280) @(negedge iClk);
      chk("bp rslt vld held", int'(sif.oRsltVld), 1);
      chk("bp rslt", int'(sif.oRslt), 78);
      chk("bp rslt id", int'(sif.oRsltId), 0);
      repeat (20) @(negedge iClk);
      chk("bp rslt stable", int'(sif.oRslt), 78);
      chk("bp no grant", gq_idx.size() - base, 1);
      chk("bp idle", int'(sif.oBusy), 0);
      sif.iRsltRdy = 1'b1;
      #1;
      chk("bp grant with consume", int'(sif.oReqRdy), 2);
      chk("bp vld in consume cycle", int'(sif.oRsltVld), 1);
      @(posedge iClk);
      #1;
      sif.iReqVld[1] = 1'b0;
      @(negedge iClk);
      chk("bp vld cleared", int'(sif.oRsltVld), 0);
      chk("bp job1 loadB", int'(sif.oLoadB), 1);
      for (int k = 0; k < 400 && !sif.oClr; k++) @(negedge iClk);
      chk("bp job1 rslt", int'(sif.oRslt), 11);
      chk("bp job1 id", int'(sif.oRsltId), 1);
      @(negedge iClk);

      // Async reset with the run counter at 100
      set_req(0, 134, 128);
      wait_rdy(0, g);
      @(posedge iClk);
      #1;
      sif.iReqVld[0] = 1'b0;
      en_n = 0;
      for (int k = 0; k < 400 && en_n < 101; k++) begin
         @(negedge iClk);
         if (sif.oEn) en_n++;
      end
      iRstN = 1'b0;
      #1;
      chk("mid rst oEn", int'(sif.oEn), 0);
      chk("mid rst oBusy", int'(sif.oBusy), 0);
      chk("mid rst oA", int'(sif.oA), 0);
      chk("mid rst oB", int'(sif.oB), 0);
      chk("mid rst oRsltVld", int'(sif.oRsltVld), 0);
      chk("mid rst oRslt", int'(sif.oRslt), 0);
      @(negedge iClk);
      iRstN = 1'b1;
      cnt = 0;
      for (int k = 0; k < 300; k++) begin
         @(negedge iClk);
         if (sif.oRsltVld || sif.oBusy) cnt++;
      end
      chk("post rst quiet", cnt, 0);
      run_job("post rst job", 0, 134, 128, 67);

`ifdef REP_UMUL_SCHED_ABORT_EN
      @(negedge iClk);
      set_req(1, 80, 90);
      wait_rdy(1, g);
      @(posedge iClk);
      #1;
      sif.iReqVld[1] = 1'b0;
      en_n = 0;
      for (int k = 0; k < 400 && en_n < 51; k++) begin
         @(negedge iClk);
         if (sif.oEn) en_n++;
      end
      sif.iAbort = 1'b1;
      @(negedge iClk);
      sif.iAbort = 1'b0;
      chk("abort oEn drop", int'(sif.oEn), 0);
      chk("abort oClr", int'(sif.oClr), 1);
      chk("abort no vld", int'(sif.oRsltVld), 0);
      @(negedge iClk);
      chk("abort clr one cycle", int'(sif.oClr), 0);
      chk("abort idle", int'(sif.oBusy), 0);
      chk("abort still no vld", int'(sif.oRsltVld), 0);
      run_job("after abort", 0, 90, 80, 28);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
